// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide engine for the EX stage. Handles MULT, MULTU,
//   DIV and DIVU with one shift-add (multiply) or restoring-subtract (divide)
//   step per cycle. After the steps, one fix-up cycle applies signs. A final
//   cycle pulses the Hi/Lo write enables. While an operation is in flight it
//   raises Stall toward hazard detection, so MFHI/MFLO and a new mult/div wait.
//
//   Ports
//     Clk, Rst          clock (rising edge), asynchronous active-high reset
//     Start, Op         launch request and opcode (00 MULT, 01 MULTU, 10 DIV,
//                       11 DIVU); sampled only while idle
//     OpA, OpB          rs / rt operands after forwarding
//     Kill              flush: abandon the running operation without writing
//     HiLoRead          ID stage holds MFHI/MFLO
//     Busy, Stall       engine occupied / pipeline hold request
//     Done, Hi_Write,   one-cycle pulse with the result on Hi_out/Lo_out
//     Lo_Write
//     Hi_out, Lo_out    product high/low, or remainder/quotient
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Kill,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             Hi_Write,
  output logic             Lo_Write,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t stateReg, stateNext;

  logic [CW-1:0]    countReg;
  logic             opDivReg, opSignedReg;
  logic             signAReg, signBReg;
  logic             divZeroReg;
  logic [WIDTH-1:0] operandReg;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] accHiReg;     // product upper half / partial remainder
  logic [WIDTH-1:0] accLoReg;     // multiplier shifting out / quotient shifting in

  // Launch decode: magnitudes for signed ops. The most negative value negates
  // to itself, which read as unsigned is the correct magnitude.
  logic             startSigned, startDiv, startNegA, startNegB, launch;
  logic [WIDTH-1:0] magA, magB;

  assign startSigned = ~Op[0];
  assign startDiv    = Op[1];
  assign startNegA   = startSigned & OpA[WIDTH-1];
  assign startNegB   = startSigned & OpB[WIDTH-1];
  assign magA        = startNegA ? -OpA : OpA;
  assign magB        = startNegB ? -OpB : OpB;
  assign launch      = Start & ~Kill;

  // Iteration step
  logic             lastStep;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divDiff;
  logic             divFits;

  assign lastStep = (countReg == CW'(WIDTH - 1));
  assign mulSum   = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, operandReg} : '0);
  assign divShift = {accHiReg, accLoReg[WIDTH-1]};
  assign divFits  = (divShift >= {1'b0, operandReg});
  // When the trial fits, the difference is below the divisor, so W bits suffice.
  assign divDiff  = divShift[WIDTH-1:0] - operandReg;

  // Sign fix-up
  logic               negResult, negRem;
  logic [2*WIDTH-1:0] prodRaw, prodNeg;
  logic [WIDTH-1:0]   quotFix, remFix, hiFix, loFix;

  assign negResult = opSignedReg & (signAReg ^ signBReg);
  assign negRem    = opSignedReg & signAReg;
  assign prodRaw   = {accHiReg, accLoReg};
  assign prodNeg   = -prodRaw;
  assign quotFix   = negResult ? -accLoReg : accLoReg;
  // For a zero divisor the remainder is |dividend|, so applying the dividend
  // sign returns the original OpA unchanged.
  assign remFix    = negRem ? -accHiReg : accHiReg;

  always_comb begin
    hiFix = accHiReg;
    loFix = accLoReg;
    if (opDivReg) begin
      hiFix = remFix;
      loFix = divZeroReg ? '1 : quotFix;
    end else if (negResult) begin
      hiFix = prodNeg[2*WIDTH-1:WIDTH];
      loFix = prodNeg[WIDTH-1:0];
    end
  end

  // FSM
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    Done      = 1'b0;
    unique case (stateReg)
      IDLE: if (launch) stateNext = CALC;   // a flushed instruction never launches
      CALC: begin
        if (Kill)          stateNext = IDLE;
        else if (lastStep) stateNext = FIX;
      end
      FIX:  stateNext = Kill ? IDLE : DONE;
      DONE: begin
        Done      = 1'b1;
        stateNext = IDLE;                   // Kill and Start ignored here
      end
      default: stateNext = IDLE;
    endcase
  end

  assign Busy     = (stateReg != IDLE);
  assign Stall    = Busy & (HiLoRead | Start);
  assign Hi_Write = Done;
  assign Lo_Write = Done;

  // Datapath
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      countReg    <= '0;
      opDivReg    <= 1'b0;
      opSignedReg <= 1'b0;
      signAReg    <= 1'b0;
      signBReg    <= 1'b0;
      divZeroReg  <= 1'b0;
      operandReg  <= '0;
      accHiReg    <= '0;
      accLoReg    <= '0;
      Hi_out      <= '0;
      Lo_out      <= '0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (launch) begin
            countReg    <= '0;
            opDivReg    <= startDiv;
            opSignedReg <= startSigned;
            signAReg    <= startNegA;
            signBReg    <= startNegB;
            divZeroReg  <= startDiv & (OpB == '0);
            operandReg  <= startDiv ? magB : magA;
            accHiReg    <= '0;
            accLoReg    <= startDiv ? magA : magB;
          end
        end
        CALC: begin
          countReg <= countReg + 1'b1;
          if (opDivReg) begin
            accHiReg <= divFits ? divDiff : divShift[WIDTH-1:0];
            accLoReg <= {accLoReg[WIDTH-2:0], divFits};
          end else begin
            accHiReg <= mulSum[WIDTH:1];
            accLoReg <= {mulSum[0], accLoReg[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!Kill) begin
            Hi_out <= hiFix;
            Lo_out <= loFix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: scoreboard of expected {Hi,Lo} pushed
// at launch and popped when Done pulses, plus latency, stall, kill and reset
// checks.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         Clk;
  logic         Rst, Start, Kill, HiLoRead;
  logic [1:0]   Op;
  logic [W-1:0] OpA, OpB;
  logic         Busy, Stall, Done, Hi_Write, Lo_Write;
  logic [W-1:0] Hi_out, Lo_out;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Kill(Kill), .HiLoRead(HiLoRead), .Busy(Busy), .Stall(Stall), .Done(Done),
    .Hi_Write(Hi_Write), .Lo_Write(Lo_Write), .Hi_out(Hi_out), .Lo_out(Lo_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] sb[$];
  logic [W-1:0] lastHi, lastLo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {Hi, Lo}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sbv;
    logic signed [W-1:0] q, r;
    sa  = $signed(a);
    sbv = $signed(b);
    case (op)
      2'b00: return sa * sbv;
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge. Launches one op, optionally holds Start (with other
  // operands) for holdStart busy cycles and/or holds HiLoRead, then waits for Done.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [63:0] expHL,
                       input bit probeStall, input int holdStart);
    int lat;
    logic [63:0] e;
    sb.push_back(expHL);
    Op = op; OpA = a; OpB = b; Start = 1'b1; HiLoRead = probeStall;
    @(posedge Clk); lat = 1;
    @(negedge Clk);
    for (int i = 0; i < holdStart; i++) begin
      Op = ~op; OpA = ~a; OpB = b + 1;
      check({tag, "_stall_start"}, 64'(Stall), 64'd1);
      @(posedge Clk); lat++;
      @(negedge Clk);
    end
    Start = 1'b0; OpA = '0; OpB = '0;
    while (!Done && lat < 60) begin
      if (probeStall) check({tag, "_stall_hilo"}, 64'(Stall), 64'd1);
      @(posedge Clk); lat++;
      @(negedge Clk);
    end
    e = sb.pop_front();
    if (!Done) begin
      check({tag, "_done_timeout"}, 64'(Done), 64'd1);
    end else begin
      $display("op %s: Op=%0d A=%h B=%h -> Hi=%h Lo=%h latency=%0d", tag, op, a, b, Hi_out, Lo_out, lat);
      check({tag, "_hi"}, 64'(Hi_out), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(Lo_out), 64'(e[31:0]));
      check({tag, "_latency"}, 64'(lat), 64'd34);
      check({tag, "_write_en"}, {62'd0, Hi_Write, Lo_Write}, 64'd3);
      if (probeStall) check({tag, "_stall_done"}, 64'(Stall), 64'd1);
      @(posedge Clk);
      @(negedge Clk);
      check({tag, "_done_pulse"}, 64'(Done), 64'd0);
      check({tag, "_idle_after"}, {62'd0, Busy, Stall}, 64'd0);
    end
    lastHi = e[63:32];
    lastLo = e[31:0];
    HiLoRead = 1'b0;
  endtask

  initial begin
    int doneCount;
    logic [W-1:0] ra, rb;
    logic [1:0] rop;
    Rst = 1'b1; Start = 1'b0; Kill = 1'b0; HiLoRead = 1'b0;
    Op = 2'b00; OpA = '0; OpB = '0;
    repeat (3) @(negedge Clk);
    check("reset_ctrl", {59'd0, Busy, Stall, Done, Hi_Write, Lo_Write}, 64'd0);
    check("reset_hilo", {Hi_out, Lo_out}, 64'd0);
    Rst = 1'b0;
    @(negedge Clk);
    HiLoRead = 1'b1;
    check("idle_no_stall", 64'(Stall), 64'd0);
    HiLoRead = 1'b0;

    runOp("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 0);
    runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 0);
    runOp("mult_m1m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 0);
    runOp("div_m7d2",  2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);
    runOp("divu_100d7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 0);
    runOp("divu_by0",  2'b11, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b0, 0);
    runOp("div_by0_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, 1'b0, 0);
    runOp("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 0);
    runOp("mult_minneg", 2'b00, 32'h8000_0000, 32'd3, model(2'b00, 32'h8000_0000, 32'd3), 1'b0, 0);

    // Start held while busy must not be latched
    runOp("start_busy", 2'b10, 32'd1000, 32'hFFFF_FFFD, model(2'b10, 32'd1000, 32'hFFFF_FFFD), 1'b1, 3);

    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = (i == 2) ? 32'd0 : $urandom;
      rop = 2'(i % 4);
      runOp($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b0, 0);
    end

    // Kill at CALC step 10: no Done, Hi/Lo unchanged
    Op = 2'b01; OpA = 32'd12345; OpB = 32'd678; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    check("kill_busy_before", 64'(Busy), 64'd1);
    Kill = 1'b1;
    @(negedge Clk);
    Kill = 1'b0;
    check("kill_idle_next", 64'(Busy), 64'd0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) doneCount++;
    end
    $display("op kill: Hi=%h Lo=%h done_pulses=%0d", Hi_out, Lo_out, doneCount);
    check("kill_no_done", 64'(doneCount), 64'd0);
    check("kill_hilo_kept", {Hi_out, Lo_out}, {lastHi, lastLo});

    // Asynchronous reset between edges mid-CALC
    Op = 2'b00; OpA = 32'd77; OpB = 32'd99; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    $display("op reset_mid: Busy=%b Hi=%h Lo=%h", Busy, Hi_out, Lo_out);
    check("rst_mid_ctrl", {59'd0, Busy, Stall, Done, Hi_Write, Lo_Write}, 64'd0);
    check("rst_mid_hilo", {Hi_out, Lo_out}, 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    runOp("after_rst", 2'b00, 32'hFFFF_FF9C, 32'd250, model(2'b00, 32'hFFFF_FF9C, 32'd250), 1'b0, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
